// File: rtl/lock_pkg.sv
// lock_pkg: state encoding, display symbols and press-decoding helpers shared by the lock datapath.
package lock_pkg;
    typedef enum logic [2:0] {IDLE, ENTRY, UNLOCKED, PROG, LOCKOUT} state_t;
    // Symbols 0-9 are the decimal digits themselves
    localparam logic [3:0] SYM_L     = 4'hA;
    localparam logic [3:0] SYM_U     = 4'hB;
    localparam logic [3:0] SYM_P     = 4'hC;
    localparam logic [3:0] SYM_DASH  = 4'hD;
    localparam logic [3:0] SYM_BLANK = 4'hF;
    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        return v[1] ? 2'd1 : v[2] ? 2'd2 : v[3] ? 2'd3 : 2'd0;
    endfunction
    function automatic logic is_onehot(input logic [3:0] v);
        return v != 4'd0 && (v & (v - 4'd1)) == 4'd0;
    endfunction
endpackage

// File: rtl/lock_sequencer_if.sv
// lock_sequencer_if: button/prog pulses in, display symbols and status out.
interface lock_sequencer_if;
    logic [3:0] press;
    logic       prog;
    logic [3:0] sym0;
    logic [3:0] sym1;
    logic [3:0] sym2;
    logic [3:0] sym3;
    logic       unlocked;
    logic       locked_out;
    logic [2:0] fail_cnt;
    modport master (output press, prog, input sym0, sym1, sym2, sym3, unlocked, locked_out, fail_cnt);
    modport slave  (input press, prog, output sym0, sym1, sym2, sym3, unlocked, locked_out, fail_cnt);
endinterface

// File: rtl/sec_timer.sv
// sec_timer: CLK_HZ prescaler feeding a 4-bit seconds down-counter; zero pulses once when the count hits 0.
module sec_timer #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       run,
    output logic [3:0] count,
    output logic       zero
);
    localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
    logic [PW-1:0] pre;
    logic tick;
    assign tick = run && count != 4'd0 && pre == PW'(CLK_HZ - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pre   <= '0;
            count <= 4'd0;
            zero  <= 1'b0;
        end else begin
            zero <= !load && tick && count == 4'd1;
            if (load) begin
                pre   <= '0;
                count <= load_val;
            end else if (run && count != 4'd0) begin
                pre <= tick ? '0 : pre + 1'b1;
                if (tick) count <= count - 4'd1;
            end
        end
endmodule

// File: rtl/lock_sequencer.sv
// lock_sequencer: 4-press combination lock controller with failure lockout; AUTO_RELOCK_EN adds timed relock.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int         CLK_HZ       = 100_000_000,
    parameter int         MAX_FAIL     = 3,
    parameter int         LOCKOUT_S    = 9,
    parameter logic [7:0] CODE_DEFAULT = 8'b11_10_01_00
) (
    input logic clk,
    input logic rst,
    lock_sequencer_if.slave bus
);
    state_t state, state_n;
    logic [1:0] idx, pidx;
    logic [7:0] entry, code;
    logic [2:0] fail;
    logic [15:0] sym, sym_n;
    logic bad, valid, any, last, match, lock_hit, load, run, zero;
    logic [3:0] count;
    assign valid    = is_onehot(bus.press);
    assign pidx     = onehot_idx(bus.press);
    assign any      = |bus.press;
    assign last     = idx == 2'd3;
    assign match    = !bad && valid && {pidx, entry[5:0]} == code;
    assign lock_hit = {1'b0, fail} + 4'd1 >= 4'(MAX_FAIL);
`ifdef AUTO_RELOCK_EN
    assign load = state_n != state && (state_n == LOCKOUT || state_n == UNLOCKED);
    assign run  = state == LOCKOUT || state == UNLOCKED;
`else
    assign load = state_n != state && state_n == LOCKOUT;
    assign run  = state == LOCKOUT;
`endif
    sec_timer #(.CLK_HZ(CLK_HZ)) u_timer (
        .clk(clk), .rst(rst), .load(load), .load_val(4'(LOCKOUT_S)),
        .run(run), .count(count), .zero(zero)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (valid) state_n = ENTRY;
            ENTRY:    if (any && last) state_n = match ? UNLOCKED : lock_hit ? LOCKOUT : IDLE;
`ifdef AUTO_RELOCK_EN
            UNLOCKED: state_n = bus.prog ? PROG : (any || zero) ? IDLE : UNLOCKED;
`else
            UNLOCKED: state_n = bus.prog ? PROG : any ? IDLE : UNLOCKED;
`endif
            PROG:     if (valid && last) state_n = IDLE;
            LOCKOUT:  if (zero) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end
    // Transitions repaint the whole display; within ENTRY/PROG each press marks its digit
    always_comb begin
        sym_n = state_n == state ? sym :
                state_n == IDLE     ? {4{SYM_L}} :
                state_n == UNLOCKED ? {4{SYM_U}} :
                state_n == PROG     ? {SYM_P, {3{SYM_BLANK}}} :
                state_n == LOCKOUT  ? {SYM_L, SYM_BLANK, SYM_BLANK, 4'd0} :
                                      {SYM_DASH, {3{SYM_BLANK}}};
        if (state_n == state && (state == ENTRY ? any : state == PROG && valid)) sym_n[{~idx, 2'b00} +: 4] = SYM_DASH;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            idx   <= 2'd0;
            entry <= 8'd0;
            bad   <= 1'b0;
            code  <= CODE_DEFAULT;
            fail  <= 3'd0;
            sym   <= {4{SYM_L}};
        end else begin
            sym <= sym_n;
            case (state)
                IDLE: if (valid) begin
                    entry[1:0] <= pidx;
                    idx        <= 2'd1;
                    bad        <= 1'b0;
                end
                ENTRY: if (any) begin
                    entry[{idx, 1'b0} +: 2] <= pidx;
                    idx <= idx + 2'd1;
                    bad <= bad | !valid;
                    if (last) fail <= match ? 3'd0 : lock_hit ? 3'(MAX_FAIL) : fail + 3'd1;
                end
                UNLOCKED: if (bus.prog) idx <= 2'd0;
                PROG: if (valid) begin
                    entry[{idx, 1'b0} +: 2] <= pidx;
                    idx <= idx + 2'd1;
                    if (last) begin
                        code <= {pidx, entry[5:0]};
                        fail <= 3'd0;
                    end
                end
                LOCKOUT: if (zero) fail <= 3'd0;
                default: ;
            endcase
        end
`ifdef AUTO_RELOCK_EN
    assign bus.sym0 = (state == LOCKOUT || state == UNLOCKED) ? count : sym[3:0];
`else
    assign bus.sym0 = state == LOCKOUT ? count : sym[3:0];
`endif
    assign bus.sym1       = sym[7:4];
    assign bus.sym2       = sym[11:8];
    assign bus.sym3       = sym[15:12];
    assign bus.unlocked   = state == UNLOCKED;
    assign bus.locked_out = state == LOCKOUT;
    assign bus.fail_cnt   = fail;
endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer: directed and random press sequences checked every cycle against a list-based lock model.
module tb_lock_sequencer;
    localparam int CLK_HZ = 10, MAX_FAIL = 3, LOCKOUT_S = 9;
    localparam logic [3:0] L = 4'hA, U = 4'hB, P = 4'hC, D = 4'hD, B = 4'hF;
    logic clk = 1'b0;
    logic rst = 1'b1;
    lock_sequencer_if bus ();
    lock_sequencer #(.CLK_HZ(CLK_HZ), .MAX_FAIL(MAX_FAIL), .LOCKOUT_S(LOCKOUT_S),
                     .CODE_DEFAULT(8'b11_10_01_00)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int passed = 0, total = 0;
    int mode, fails, lock_t;
    int code[4];
    int got[$];
    int newc[$];
    logic [3:0] disp[4];
    function automatic void show(input logic [3:0] a, b, c, d);
        disp[3] = a; disp[2] = b; disp[1] = c; disp[0] = d;
    endfunction
    function automatic void model_reset();
        mode = 0; fails = 0; lock_t = 0;
        code = '{0, 1, 2, 3};
        got = {}; newc = {};
        show(L, L, L, L);
    endfunction
    // mode: 0 idle, 1 entering, 2 open, 3 programming, 4 locked out
    function automatic void model_step(input logic [3:0] p, input logic pg);
        bit one = $countones(p) == 1;
        int k = one ? $clog2(p) : -1;
        bit ok = 1;
        case (mode)
            0: if (one) begin got = {k}; mode = 1; show(D, B, B, B); end
            1: if (p != 0) begin
                got.push_back(k);
                disp[4 - got.size()] = D;
                if (got.size() == 4) begin
                    for (int i = 0; i < 4; i++) if (got[i] != code[i]) ok = 0;
                    if (ok) begin mode = 2; fails = 0; show(U, U, U, U); end
                    else begin
                        fails++;
                        if (fails == MAX_FAIL) begin mode = 4; lock_t = 0; show(L, B, B, 0); end
                        else begin mode = 0; show(L, L, L, L); end
                    end
                end
            end
            2: if (pg) begin mode = 3; newc = {}; show(P, B, B, B); end
               else if (p != 0) begin mode = 0; show(L, L, L, L); end
            3: if (one) begin
                newc.push_back(k);
                disp[4 - newc.size()] = D;
                if (newc.size() == 4) begin
                    for (int i = 0; i < 4; i++) code[i] = newc[i];
                    fails = 0; mode = 0; show(L, L, L, L);
                end
            end
            default: begin
                lock_t++;
                if (lock_t > LOCKOUT_S * CLK_HZ) begin mode = 0; fails = 0; show(L, L, L, L); end
            end
        endcase
    endfunction
    function automatic logic [20:0] expected();
        logic [3:0] s0 = mode == 4 ? 4'(LOCKOUT_S - lock_t / CLK_HZ) : disp[0];
        return {disp[3], disp[2], disp[1], s0, mode == 2, mode == 4, 3'(fails)};
    endfunction
    task automatic check(input string tag);
        logic [20:0] obs = {bus.sym3, bus.sym2, bus.sym1, bus.sym0, bus.unlocked, bus.locked_out, bus.fail_cnt};
        logic [20:0] exp = expected();
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask
    task automatic cyc(input logic [3:0] p, input logic pg = 1'b0, input string tag = "step");
        bus.press = p; bus.prog = pg;
        @(posedge clk);
        model_step(p, pg);
        #1 check(tag);
        bus.press = 4'd0; bus.prog = 1'b0;
    endtask
    task automatic enter(input int a, b, c, d, input string tag);
        cyc(4'(1 << a), 1'b0, tag); cyc(4'(1 << b), 1'b0, tag);
        cyc(4'(1 << c), 1'b0, tag); cyc(4'(1 << d), 1'b0, tag);
    endtask
    task automatic do_reset(input string tag);
        rst = 1'b1; bus.press = 4'd0; bus.prog = 1'b0;
        #2 model_reset();
        check(tag);
        @(negedge clk) rst = 1'b0;
    endtask
    initial begin
        bus.press = 4'd0; bus.prog = 1'b0;
        repeat (2) @(posedge clk);
        do_reset("reset");
        enter(0, 1, 2, 3, "unlock");
        cyc(4'd1, 1'b0, "relock");
        repeat (3) enter(3, 2, 1, 0, "wrong");
        repeat (91) cyc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "lockout");
        cyc(4'd0, 1'b0, "after_lockout");
        enter(0, 1, 2, 3, "unlock2");
        cyc(4'd0, 1'b1, "prog");
        enter(3, 3, 0, 1, "newcode");
        enter(0, 1, 2, 3, "oldcode");
        enter(3, 3, 0, 1, "unlock3");
        cyc(4'd2, 1'b0, "leave");
        cyc(4'd8, 1'b0, "poison"); cyc(4'd8, 1'b0, "poison");
        cyc(4'd3, 1'b0, "poison"); cyc(4'd2, 1'b0, "poison");
        enter(3, 3, 0, 1, "unlock4");
        cyc(4'd1, 1'b1, "prog_wins");
        enter(0, 1, 2, 3, "reprog");
        cyc(4'd1, 1'b0, "partial"); cyc(4'd2, 1'b0, "partial");
        do_reset("rst_entry");
        enter(0, 1, 2, 3, "unlock5");
        cyc(4'd0, 1'b1, "prog2"); cyc(4'd8, 1'b0, "prog2"); cyc(4'd4, 1'b0, "prog2");
        do_reset("rst_prog");
        enter(0, 1, 2, 3, "default_code");
        for (int it = 0; it < 60; it++)
            case ($urandom_range(0, 3))
                0: enter(code[0], code[1], code[2], code[3], "rand_code");
                1: repeat (4) cyc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 7) == 0), "rand_press");
                2: begin
                    cyc(4'd0, 1'b1, "rand_prog");
                    repeat (4) cyc(4'(1 << $urandom_range(0, 3)), 1'b0, "rand_prog");
                end
                default: repeat ($urandom_range(1, 30)) cyc(4'd0, 1'b0, "rand_idle");
            endcase
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
